// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART byte receiver with selectable baud rate.
// A two-flop synchronizer feeds a third flop for falling-edge detection.
// After a start edge, the bit period is fixed for the rest of the frame.
// Each bit is sampled at its centre, and data bits arrive LSB first.
//
// Ports:
//   clk       - system clock; all logic runs on the rising edge
//   reset_n   - synchronous active-low reset
//   baud_set  - baud select: 0=9600, 1=19200, 2=38400, 3=57600,
//               4=115200, others=9600
//   uart_rx   - asynchronous serial input, idle high
//   data      - last byte received with a valid stop bit
//   rx_done   - one-cycle pulse when data is updated
//   frame_err - one-cycle pulse when the stop bit is low
//   rx_busy   - high from start-edge detect until the FSM returns to IDLE
module uart_byte_rx #(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] baud_set,
  input  logic       uart_rx,
  output logic [7:0] data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned CNT_W = 13;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned DAT_W = 8;
  localparam int unsigned IDX_W = 3;

  // Bit periods in clocks. Each value is the integer part of CLK_HZ / baud.
  localparam logic [CNT_W-1:0] DIV_9600   = CNT_W'(CLK_HZ / 9600);
  localparam logic [CNT_W-1:0] DIV_19200  = CNT_W'(CLK_HZ / 19200);
  localparam logic [CNT_W-1:0] DIV_38400  = CNT_W'(CLK_HZ / 38400);
  localparam logic [CNT_W-1:0] DIV_57600  = CNT_W'(CLK_HZ / 57600);
  localparam logic [CNT_W-1:0] DIV_115200 = CNT_W'(CLK_HZ / 115200);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               rx_s1;
  logic               rx_s2;
  logic               rx_s3;
  logic [1:0]         sync_vld;
  logic               armed;
  logic [SEL_W-1:0]   baud_q;
  logic [SEL_W-1:0]   baud_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [IDX_W-1:0]   bit_idx;
  logic [IDX_W-1:0]   bit_idx_nxt;
  logic [DAT_W-1:0]   shreg;
  logic [DAT_W-1:0]   shreg_nxt;
  logic [DAT_W-1:0]   data_nxt;
  logic               done_nxt;
  logic               err_nxt;
  logic               busy_nxt;
  logic               start_edge;
  logic               sample_tick;
  logic [CNT_W-1:0]   period_new;
  logic [CNT_W-1:0]   period_cur;

  function automatic logic [CNT_W-1:0] bit_period(input logic [SEL_W-1:0] sel);
    case (sel)
      4'd1:    bit_period = DIV_19200;
      4'd2:    bit_period = DIV_38400;
      4'd3:    bit_period = DIV_57600;
      4'd4:    bit_period = DIV_115200;
      default: bit_period = DIV_9600;
    endcase
  endfunction

  assign period_new  = bit_period(baud_set);
  assign period_cur  = bit_period(baud_q);
  // armed stays clear until a real high level has passed the synchronizer,
  // so a line held low across reset release cannot look like a start edge.
  assign start_edge  = armed & rx_s3 & ~rx_s2;
  assign sample_tick = (cnt == '0);

  // Synchronizer, edge-detect flop and post-reset line qualification.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      sync_vld <= '0;
      armed    <= 1'b0;
    end else begin
      rx_s1    <= uart_rx;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      sync_vld <= {sync_vld[0], 1'b1};
      armed    <= armed | (sync_vld[1] & rx_s2);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_edge) state_nxt = START;
      end
      START: begin
        if (sample_tick) state_nxt = rx_s2 ? IDLE : DATA;
      end
      DATA: begin
        if (sample_tick && (bit_idx == IDX_W'(DAT_W - 1))) state_nxt = STOP;
      end
      STOP: begin
        if (sample_tick) state_nxt = rx_s2 ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (rx_s2) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    // The counter saturates at zero instead of wrapping.
    cnt_nxt     = (cnt != '0) ? (cnt - CNT_W'(1)) : cnt;
    baud_nxt    = baud_q;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    data_nxt    = data;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          // Load half a period first so that every sample lands mid-bit.
          baud_nxt    = baud_set;
          cnt_nxt     = (period_new >> 1) - CNT_W'(1);
          bit_idx_nxt = '0;
        end
      end
      START: begin
        if (sample_tick) begin
          cnt_nxt = rx_s2 ? '0 : (period_cur - CNT_W'(1));
        end
      end
      DATA: begin
        if (sample_tick) begin
          shreg_nxt   = {rx_s2, shreg[DAT_W-1:1]};
          bit_idx_nxt = bit_idx + IDX_W'(1);
          cnt_nxt     = period_cur - CNT_W'(1);
        end
      end
      STOP: begin
        if (sample_tick) begin
          cnt_nxt = '0;
          if (rx_s2) begin
            data_nxt = shreg;
            done_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      default: ;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      baud_q    <= '0;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      baud_q    <= baud_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shreg     <= shreg_nxt;
      data      <= data_nxt;
      rx_done   <= done_nxt;
      frame_err <= err_nxt;
      rx_busy   <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: directed and randomized frames for uart_byte_rx.
// The expected pulse cycle, data value and busy window are derived from
// the bit timing of each frame. The DUT outputs are compared every cycle.
module tb_uart_byte_rx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] baud_set;
  logic       uart_rx;
  logic [7:0] data;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;

  always #5 clk = ~clk;

  uart_byte_rx #(.CLK_HZ(50000000)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .baud_set  (baud_set),
    .uart_rx   (uart_rx),
    .data      (data),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         done_at = -1;
  int         err_at = -1;
  int         busy_lo = 0;
  int         busy_hi = 0;
  logic [7:0] exp_data = 8'h00;
  logic [7:0] pend_data = 8'h00;

  // Bit period = integer part of 50 MHz / baud rate.
  function automatic int bit_period(input logic [3:0] sel);
    int rate;
    case (sel)
      4'd1:    rate = 19200;
      4'd2:    rate = 38400;
      4'd3:    rate = 57600;
      4'd4:    rate = 115200;
      default: rate = 9600;
    endcase
    return 50000000 / rate;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one clock, then compare all outputs against the model.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc == done_at) exp_data = pend_data;
    check("rx_done", 8'(rx_done), 8'(cyc == done_at));
    check("frame_err", 8'(frame_err), 8'(cyc == err_at));
    check("rx_busy", 8'(rx_busy), 8'((cyc >= busy_lo) && (cyc < busy_hi)));
    check("data", data, exp_data);
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) tick();
  endtask

  // Send one 8N1 frame. The line falls at cycle c. Edge detect is at c+3
  // (two synchronizer flops plus the edge flop). The stop sample is at
  // c+3+D/2+9D, and any pulse becomes visible from that cycle.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit chg_baud);
    int         d;
    int         c;
    int         s;
    logic [3:0] orig;
    logic [9:0] bits;
    orig      = baud_set;
    d         = bit_period(baud_set);
    c         = cyc;
    s         = c + 3 + d / 2 + 9 * d;
    bits      = {stop_ok, b, 1'b0};
    pend_data = b;
    done_at   = stop_ok ? s : -1;
    err_at    = stop_ok ? -1 : s;
    busy_lo   = c + 3;
    // A bad stop bit holds busy until the line has been high for two cycles.
    busy_hi   = stop_ok ? s : (c + 10 * d + 3);
    for (int k = 0; k < 10; k++) begin
      uart_rx = bits[k];
      if (chg_baud && (k == 3)) baud_set = 4'($urandom_range(0, 15));
      repeat (d) tick();
    end
    uart_rx  = 1'b1;
    baud_set = orig;
  endtask

  initial begin
    int         c;
    int         d;
    logic [7:0] b;
    logic [9:0] bits;

    // Reset state.
    reset_n  = 1'b0;
    uart_rx  = 1'b1;
    baud_set = 4'd4;
    repeat (5) tick();
    reset_n = 1'b1;
    idle(20 + 32'($urandom_range(0, 20)));

    // Two back-to-back frames at 115200.
    send_frame(8'h87, 1'b1, 1'b0);
    send_frame(8'h48, 1'b1, 1'b0);
    idle(32'($urandom_range(3, 30)));

    // A 100-clock low glitch is a false start: rx_busy drops at the start-bit sample.
    d       = bit_period(4'd4);
    c       = cyc;
    done_at = -1;
    err_at  = -1;
    busy_lo = c + 3;
    busy_hi = c + 3 + d / 2;
    uart_rx = 1'b0;
    repeat (100) tick();
    idle(d);

    // A bad stop bit gives frame_err, and the next valid frame is still received.
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(32'($urandom_range(3, 30)));
    send_frame(8'h55, 1'b1, 1'b0);
    idle(32'($urandom_range(3, 30)));

    // Reset during data bit 4, with the line held low across reset release.
    b       = 8'hE5;
    bits    = {1'b1, b, 1'b0};
    c       = cyc;
    done_at = -1;
    err_at  = -1;
    busy_lo = c + 3;
    busy_hi = 32'h7fffffff;
    for (int k = 0; k < 5; k++) begin
      uart_rx = bits[k];
      repeat (d) tick();
    end
    uart_rx = bits[5];
    repeat (d / 3) tick();
    reset_n  = 1'b0;
    busy_hi  = cyc + 1;
    exp_data = 8'h00;
    repeat (5) tick();
    reset_n = 1'b1;
    repeat (40) tick();
    idle(30);
    send_frame(8'h12, 1'b1, 1'b0);
    idle(32'($urandom_range(3, 30)));

    // Random byte, with baud_set changed in the middle of the frame.
    send_frame(8'($urandom), 1'b1, 1'b1);
    idle(32'($urandom_range(3, 30)));

    // 9600 baud, with a mid-frame baud_set change that must be ignored.
    baud_set = 4'd0;
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_byte_rx.md
UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 SHALL provide parameter CLK_HZ, default 50000000, system clock frequency in Hz; divisor table below is fixed for 50 MHz.
REQ-002 SHALL provide port clk, input, 1, single system clock; all logic on rising edge.
REQ-003 SHALL provide port reset_n, input, 1, synchronous active-low reset sampled on rising clk.
REQ-004 SHALL provide port baud_set, input, 4, baud rate select.
REQ-005 SHALL provide port uart_rx, input, 1, asynchronous serial line, idle high.
REQ-006 SHALL provide port data, output, 8, last correctly received byte.
REQ-007 SHALL provide port rx_done, output, 1, one-cycle pulse when data is updated.
REQ-008 SHALL provide port frame_err, output, 1, one-cycle pulse on bad stop bit.
REQ-009 SHALL provide port rx_busy, output, 1, high from start-edge detect until return to IDLE.

Function
REQ-010 SHALL synchronize uart_rx through two flops (reset value 1) before any use; edge detect uses a third flop.
REQ-011 SHALL map baud_set to bit period D in clocks: 0->5208 (9600), 1->2604 (19200), 2->1302 (38400), 3->868 (57600), 4->434 (115200), 5..15->5208.
REQ-012 SHALL latch baud_set into an internal register on start-edge detect; baud_set changes mid-frame have no effect on that frame.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-014 IDLE: on synchronized 1->0 transition at cycle t0, go to START and load the bit-period counter.
REQ-015 Sample k (k=0 start, 1..8 data, 9 stop) SHALL be taken at cycle t0 + floor(D/2) + k*D.
REQ-016 START: sample 0 high = false start -> IDLE, no output pulse; sample 0 low -> DATA.
REQ-017 DATA: samples 1..8 SHALL shift into a shift register LSB first; after sample 8, go to STOP.
REQ-018 STOP: sample 9 high -> data loaded from shift register and rx_done high in the next cycle for exactly one cycle, then IDLE.
REQ-019 STOP: sample 9 low -> frame_err high in the next cycle for exactly one cycle, data unchanged, go to WAIT_IDLE.
REQ-020 WAIT_IDLE: remain until the synchronized line is high, then IDLE; no start detection while in WAIT_IDLE.
REQ-021 A new start edge SHALL be accepted from the cycle IDLE is re-entered, allowing back-to-back frames with a one-bit stop.
REQ-022 rx_done and frame_err SHALL never be high in the same cycle.
REQ-023 data SHALL hold its value between rx_done pulses; partial frames never alter it.
REQ-024 The bit counter SHALL be 13 bits wide, SHALL count down, and SHALL reload with D on each sample; no wrap-around past zero.

Reset
REQ-025 While reset_n=0 at a rising edge: state=IDLE, data=8'h00, rx_done=0, frame_err=0, rx_busy=0, synchronizer flops=1, counters=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no rx_done or frame_err pulse; after release, the block waits for a fresh 1->0 edge.
REQ-027 A line held low across reset release SHALL NOT be taken as a start bit until it has been seen high.

Verification
REQ-028 baud_set=4, send 8'h87 (434 clk/bit, 8N1) -> exactly one rx_done; data=8'h87; pulse about 9.5 bit times after the start edge.
REQ-029 baud_set=4, send 8'h87 then 8'h48 back-to-back -> two rx_done pulses; data=8'h87, then 8'h48.
REQ-030 baud_set=0, send 8'hA5 -> rx_done after about 9.5*5208 clocks; data=8'hA5.
REQ-031 Low glitch of 100 clocks at baud_set=4 -> no rx_done, no frame_err, rx_busy drops after about 217 clocks.
REQ-032 8'h3C sent with stop bit forced 0 -> one frame_err pulse, no rx_done, data unchanged; next valid frame 8'h55 -> rx_done with data=8'h55.
REQ-033 reset_n low for 5 clocks during data bit 4 -> outputs at reset values, no pulse; next full frame 8'h12 -> data=8'h12.
